// File: rtl/hall_emulator.sv
`default_nettype none
// ============================================================================
// hall_emulator - emulated 3-bit hall sensor stepping at a programmable period;
// optional ramp from START_PERIOD to target when HALL_RAMP_EN is defined. Rev 1.0
// ============================================================================
module hall_emulator #(
    parameter logic [15:0] START_PERIOD = 16'd4000,
    parameter logic [15:0] RAMP_DEC     = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        direction,
    input  logic [15:0] period_set,
    output logic [2:0]  hall_signal,
    output logic        step_strobe,
    output logic        at_speed,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RAMP = 2'b01,
        RUN  = 2'b10
    } state_t;

`ifdef HALL_RAMP_EN
    localparam logic [15:0] STEP_LIMIT = RAMP_DEC;
`else
    // an all-ones limit makes every boundary land exactly on the target
    localparam logic [15:0] STEP_LIMIT = 16'hFFFF | RAMP_DEC;
`endif

    state_t      state, state_nx;
    logic [2:0]  idx, idx_nx, idx_step;
    logic [15:0] cnt, cnt_nx;
    logic [15:0] cur_period, cur_nx;
    logic        strobe, strobe_nx;
    logic [15:0] target, diff, ramped;
    logic        terminal;

    assign target   = (period_set < 16'd2) ? 16'd2 : period_set;
    assign terminal = (cnt >= cur_period - 16'd1);
    assign idx_step = direction ? ((idx == 3'd0) ? 3'd5 : idx - 3'd1)
                                : ((idx == 3'd5) ? 3'd0 : idx + 3'd1);

    // next period: move toward target by at most STEP_LIMIT, never overshooting
    always_comb begin
        if (cur_period > target) begin
            diff   = cur_period - target;
            ramped = cur_period - ((diff > STEP_LIMIT) ? STEP_LIMIT : diff);
        end else begin
            diff   = target - cur_period;
            ramped = cur_period + ((diff > STEP_LIMIT) ? STEP_LIMIT : diff);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= 16'd0;
            cur_period <= START_PERIOD;
            strobe     <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            cur_period <= cur_nx;
            strobe     <= strobe_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        cur_nx    = cur_period;
        strobe_nx = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = 16'd0;
                if (enable) begin
`ifdef HALL_RAMP_EN
                    state_nx = RAMP;
                    cur_nx   = START_PERIOD;
`else
                    state_nx = RUN;
                    cur_nx   = target;
`endif
                end
            end
            RAMP: begin
                if (!enable) begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                end else if (terminal) begin
                    idx_nx    = idx_step;
                    strobe_nx = 1'b1;
                    cnt_nx    = 16'd0;
                    cur_nx    = ramped;
                    if (ramped == target) begin
                        state_nx = RUN;
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nx = IDLE;
                    cnt_nx   = 16'd0;
                end else begin
                    if (terminal) begin
                        idx_nx    = idx_step;
                        strobe_nx = 1'b1;
                        cnt_nx    = 16'd0;
`ifndef HALL_RAMP_EN
                        cur_nx    = ramped;
`endif
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
`ifdef HALL_RAMP_EN
                    if (target != cur_period) begin
                        state_nx = RAMP;
                    end
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    always_comb begin
        case (idx)
            3'd0:    hall_signal = 3'b001;
            3'd1:    hall_signal = 3'b011;
            3'd2:    hall_signal = 3'b010;
            3'd3:    hall_signal = 3'b110;
            3'd4:    hall_signal = 3'b100;
            3'd5:    hall_signal = 3'b101;
            default: hall_signal = 3'b001;
        endcase
    end

`ifdef HALL_RAMP_EN
    assign at_speed = (state == RUN) && (cur_period == target);
`else
    assign at_speed = (state == RUN);
`endif

    assign step_strobe = strobe;
    assign state_out   = state;

endmodule
`default_nettype wire

// File: tb/tb_hall_emulator.sv
`default_nettype none
// ============================================================================
// tb_hall_emulator - randomized bench for hall_emulator against a step-level
// reference model; directed scenarios for ramp, reversal, clamp and enable. Rev 1.0
// ============================================================================
module tb_hall_emulator;

`ifdef HALL_RAMP_EN
    localparam bit RAMP_BUILD = 1'b1;
`else
    localparam bit RAMP_BUILD = 1'b0;
`endif
    localparam logic [15:0] START_P = 16'd400;
    localparam logic [15:0] DEC     = 16'd100;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        direction;
    logic [15:0] period_set;
    logic [2:0]  hall_signal;
    logic        step_strobe;
    logic        at_speed;
    logic [1:0]  state_out;

    hall_emulator #(
        .START_PERIOD(START_P),
        .RAMP_DEC    (DEC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .direction  (direction),
        .period_set (period_set),
        .hall_signal(hall_signal),
        .step_strobe(step_strobe),
        .at_speed   (at_speed),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: position in the code sequence, clocks into the step,
    // current step length and whether the speed is still being ramped
    int codes [6] = '{1, 3, 2, 6, 4, 5};
    int pos, elapsed, period;
    bit busy, ramping, m_strobe;

    function automatic int tgt_of(input logic [15:0] p);
        return (p < 16'd2) ? 2 : int'(p);
    endfunction

    function automatic int toward(input int cur, input int tgt);
        int d;
        d = (cur > tgt) ? cur - tgt : tgt - cur;
        if (d > int'(DEC)) d = int'(DEC);
        return (cur > tgt) ? cur - d : cur + d;
    endfunction

    task automatic model_reset();
        pos = 0; elapsed = 0; period = int'(START_P);
        busy = 0; ramping = 0; m_strobe = 0;
    endtask

    task automatic model_edge();
        int tgt;
        tgt = tgt_of(period_set);
        m_strobe = 0;
        if (!enable) begin
            busy = 0; ramping = 0; elapsed = 0;
        end else if (!busy) begin
            busy = 1; elapsed = 0; ramping = RAMP_BUILD;
            period = RAMP_BUILD ? int'(START_P) : tgt;
        end else begin
            elapsed++;
            if (elapsed >= period) begin
                pos = direction ? (pos + 5) % 6 : (pos + 1) % 6;
                m_strobe = 1; elapsed = 0;
                if (!RAMP_BUILD) period = tgt;
                else if (ramping) period = toward(period, tgt);
                if (RAMP_BUILD) ramping = (period != tgt);
            end else if (RAMP_BUILD && !ramping) begin
                ramping = (period != tgt);
            end
        end
    endtask

    task automatic compare_all();
        int exp_state;
        bit exp_at;
        exp_state = busy ? (ramping ? 1 : 2) : 0;
        exp_at = busy && !ramping && (!RAMP_BUILD || period == tgt_of(period_set));
        check("hall", hall_signal, codes[pos]);
        check("strobe", step_strobe, m_strobe);
        check("state", state_out, exp_state);
        check("at_speed", at_speed, exp_at);
        check("legal_code", (hall_signal != 3'b000 && hall_signal != 3'b111), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset(); else model_edge();
        #1 compare_all();
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        check("async_rst_hall", hall_signal, 3'b001);
        check("async_rst_state", state_out, 2'b00);
        tick();
        reset = 1'b1;
    endtask

    int iv_q[$], code_q[$], as_q[$];

    task automatic collect(input int nsteps, input int budget);
        int n;
        iv_q.delete(); code_q.delete(); as_q.delete();
        n = 0;
        for (int i = 0; i < budget && iv_q.size() < nsteps; i++) begin
            tick();
            n++;
            if (step_strobe) begin
                iv_q.push_back(n); code_q.push_back(hall_signal); as_q.push_back(at_speed);
                n = 0;
            end
        end
        check("steps_seen", iv_q.size(), nsteps);
    endtask

    int exp_iv[4], exp_as[4], exp_code[4], exp_rev[3];
    int strobes;
    logic [2:0] saved;

    initial begin
        reset = 1'b0; enable = 1'b0; direction = 1'b0; period_set = 16'd200;
        #2 model_reset();
        compare_all();
        check("rst_hall", hall_signal, 3'b001);
        check("rst_state", state_out, 2'b00);
        check("rst_strobe", step_strobe, 1'b0);
        tick(); tick();
        reset = 1'b1;

        // idle after release with enable low
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            strobes += int'(step_strobe);
        end
        check("idle_strobes", strobes, 0);
        check("idle_hall", hall_signal, 3'b001);

        // main start-up scenario
        if (RAMP_BUILD) begin
            period_set = 16'd200;
            exp_iv = '{400, 300, 200, 200}; exp_as = '{0, 1, 1, 1};
        end else begin
            period_set = 16'd50;
            exp_iv = '{50, 50, 50, 50}; exp_as = '{1, 1, 1, 1};
        end
        exp_code = '{3, 2, 6, 4};
        enable = 1'b1;
        tick();
        check("exit_state", state_out, RAMP_BUILD ? 2'b01 : 2'b10);
        collect(4, 1500);
        for (int i = 0; i < 4 && i < iv_q.size(); i++) begin
            check("interval", iv_q[i], exp_iv[i]);
            check("step_code", code_q[i], exp_code[i]);
            check("step_at_speed", as_q[i], exp_as[i]);
        end

        // reversal mid-step at index 2
        do_reset();
        period_set = 16'd10; direction = 1'b0; enable = 1'b1;
        for (int i = 0; i < 2000 && hall_signal != 3'b010; i++) tick();
        check("reach_idx2", hall_signal, 3'b010);
        tick(); tick(); tick();
        direction = 1'b1;
        exp_rev = '{3, 1, 5};
        collect(3, 2000);
        for (int i = 0; i < 3 && i < code_q.size(); i++) check("rev_code", code_q[i], exp_rev[i]);

        // enable falls on the terminal-count clock
        for (int i = 0; i < 3000 && !(busy && !ramping && elapsed == period - 1); i++) tick();
        check("tc_reached", (busy && !ramping && elapsed == period - 1), 1);
        saved = hall_signal;
        enable = 1'b0;
        tick();
        check("tc_strobe", step_strobe, 1'b0);
        check("tc_hall", hall_signal, saved);
        check("tc_state", state_out, 2'b00);

        // period_set 0 clamps to a 2-clock step
        period_set = 16'd0; direction = 1'b0; enable = 1'b1;
        tick();
        collect(8, 2000);
        if (iv_q.size() == 8) begin
            check("clamp_iv_a", iv_q[6], 2);
            check("clamp_iv_b", iv_q[7], 2);
        end
        for (int i = 0; i < 1000; i++) tick();

        // reset mid-operation with enable held high
        do_reset();
        check("post_rel_idle", state_out, 2'b00);
        tick();

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(199, 0) == 0) enable = ~enable;
            if ($urandom_range(49, 0) == 0) direction = ~direction;
            if ($urandom_range(299, 0) == 0) period_set = 16'($urandom_range(30, 0));
            if ($urandom_range(1999, 0) == 0) do_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hall_emulator.md
HALL_EMULATOR -- requirements
Module: hall_emulator

Interface
REQ-001 Parameter START_PERIOD, default 16'd4000, clocks per step at ramp start.
REQ-002 Parameter RAMP_DEC, default 16'd100, maximum change of the step period per step during ramp.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have the port enable, input, 1 bit; high commands rotation.
REQ-006 The block SHALL have the port direction, input, 1 bit; 0 selects the forward sequence and 1 selects reverse.
REQ-007 The block SHALL have the port period_set, input, 16 bits, the target clocks per hall step.
REQ-008 The block SHALL have the port hall_signal, output, 3 bits, the emulated hall sensor code feeding the motor controller.
REQ-009 The block SHALL have the port step_strobe, output, 1 bit, a one-cycle pulse on each hall_signal change.
REQ-010 The block SHALL have the port at_speed, output, 1 bit; high while the current period equals the target period.
REQ-011 The block SHALL have the port state_out, output, 2 bits, the current FSM state encoding.

Function
REQ-012 Forward sequence, indices 0..5: 001, 011, 010, 110, 100, 101; forward increments the index mod 6, reverse decrements it mod 6 (0 wraps to 5).
REQ-013 hall_signal SHALL never be 000 or 111.
REQ-014 FSM states SHALL be IDLE=00, RAMP=01, RUN=10; encoding 11 is unreachable and SHALL recover to IDLE on the next clock.
REQ-015 IDLE: period counter held at 0, hall_signal holds its last value, step_strobe=0, at_speed=0.
REQ-016 IDLE -> RAMP SHALL occur on the first clock with enable=1; cur_period loads START_PERIOD on that transition.
REQ-017 Target = max(period_set, 2): values 0 and 1 clamp to 2.
REQ-018 Period counter counts 0..cur_period-1; at terminal count the index advances, step_strobe pulses on the same clock as the hall_signal update, and the counter returns to 0.
REQ-019 The first step change SHALL appear exactly cur_period clocks after IDLE exit.
REQ-020 RAMP: at each step boundary cur_period moves toward the target by min(RAMP_DEC, |cur_period - target|) in either direction.
REQ-021 RAMP -> RUN SHALL occur when cur_period == target after the update; at_speed=1 from that clock.
REQ-022 RUN: if the target changes, the next clock SHALL return to RAMP with at_speed=0; cur_period continues from its present value.
REQ-023 Direction is sampled only at step boundaries; a mid-step change affects the next advance only, with no extra step and no skipped code.
REQ-024 enable=0 in any state -> IDLE on the next clock; an in-progress step is abandoned without a strobe.
REQ-025 Simultaneous enable fall and terminal count: enable wins, with no step advance.
REQ-026 Arithmetic SHALL be 16-bit unsigned; no wrap-around below the target or below 2.

Reset
REQ-027 On reset low, asynchronously: state=IDLE, index=0 (hall_signal=001), counter=0, cur_period=START_PERIOD, step_strobe=0, at_speed=0, state_out=00.
REQ-028 Reset deassertion mid-operation SHALL restart from IDLE regardless of the enable level; IDLE exit requires enable=1 sampled after release.

Configuration
REQ-029 Macro HALL_RAMP_EN: when defined, ramping behaves per REQ-020..REQ-022.
REQ-030 When HALL_RAMP_EN is undefined: RAMP is never entered; IDLE -> RUN directly with cur_period=target; target changes take effect at the next step boundary; at_speed=1 whenever in RUN.

Verification
REQ-031 Scenario: reset low, then release with enable=0 -> hall_signal=001, state_out=00, no strobe for 100 clocks.
REQ-032 Scenario: ramp enabled, START_PERIOD=400, RAMP_DEC=100, period_set=200, enable=1, direction=0 -> step intervals 400, 300, 200, 200; at_speed rises after the second step; codes 011, 010, 110.
REQ-033 Scenario: running at period 10, direction toggled mid-step at index 2 -> next code 011, then 001, 101.
REQ-034 Scenario: period_set=0 -> step interval of 2 clocks; hall_signal is never 000 or 111 over 1000 clocks.
REQ-035 Scenario: enable falls on the terminal-count clock -> no strobe, hall_signal unchanged, state_out=00.
REQ-036 Scenario: HALL_RAMP_EN undefined, period_set=50 -> state_out=10 on the clock after enable, first step at 50 clocks, at_speed=1 throughout RUN.
